muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit for the eight RV32M-style ops.
// Define MULDIV_FAST_MUL_EN to compute multiplies in one cycle with a full-width multiplier.
module muldiv_unit #(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] SrcA_i,
    input  logic [DATAWIDTH-1:0] SrcB_i,
    input  logic [2:0]           MulDivCtrl_i,
    input  logic                 Start_i,
    input  logic                 Flush_i,
    input  logic                 ResultReady_i,
    output logic                 Ready_o,
    output logic                 Valid_o,
    output logic [DATAWIDTH-1:0] Result_o
);
    localparam int unsigned W    = DATAWIDTH;
    localparam int unsigned CntW = $clog2(DATAWIDTH + 1);
    localparam logic [W-1:0] MinNeg = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      op_q;
    logic            neg_q;
    // hi_q/lo_q: product (multiply) or remainder/quotient (divide); opnd_q: multiplicand or divisor
    logic [W-1:0]    hi_q, lo_q, opnd_q, result_q;

    logic           is_div, is_rem, a_signed, b_signed, a_neg, b_neg, neg_in;
    logic           div_zero, div_ovf;
    logic [W-1:0]   a_abs, b_abs, spec_res;
    logic           fast_hit;
    logic [W-1:0]   fast_res;

    always_comb begin
        is_div   = MulDivCtrl_i[2];
        is_rem   = MulDivCtrl_i[2] & MulDivCtrl_i[1];
        a_signed = (MulDivCtrl_i == 3'b001) || (MulDivCtrl_i == 3'b010) ||
                   (MulDivCtrl_i == 3'b100) || (MulDivCtrl_i == 3'b110);
        b_signed = (MulDivCtrl_i == 3'b001) || (MulDivCtrl_i == 3'b100) ||
                   (MulDivCtrl_i == 3'b110);
        a_neg    = a_signed & SrcA_i[W-1];
        b_neg    = b_signed & SrcB_i[W-1];
        a_abs    = a_neg ? -SrcA_i : SrcA_i;
        b_abs    = b_neg ? -SrcB_i : SrcB_i;
        // Remainder follows the dividend's sign only
        neg_in   = a_neg ^ (b_neg & ~is_rem);
        div_zero = is_div && (SrcB_i == '0);
        div_ovf  = is_div && !MulDivCtrl_i[0] && (SrcA_i == MinNeg) && (SrcB_i == '1);
        spec_res = '0;
        if (div_zero) begin
            spec_res = is_rem ? SrcA_i : '1;
        end else if (div_ovf) begin
            spec_res = is_rem ? '0 : SrcA_i;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_a, fast_b, fast_prod;
    always_comb begin
        fast_a    = {{W{a_neg}}, SrcA_i};
        fast_b    = {{W{b_neg}}, SrcB_i};
        fast_prod = fast_a * fast_b;
        fast_res  = (MulDivCtrl_i[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
        fast_hit  = !MulDivCtrl_i[2];
    end
`else
    always_comb begin
        fast_res = '0;
        fast_hit = 1'b0;
    end
`endif

    logic [W:0]     mul_sum, div_diff;
    logic           q_bit;
    logic [W-1:0]   hi_n, lo_n, q_fix, r_fix, res_n;
    logic [2*W-1:0] prod_fix;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_diff = {hi_q, lo_q[W-1]} - {1'b0, opnd_q};
        q_bit    = ~div_diff[W];
        if (op_q[2]) begin
            hi_n = q_bit ? div_diff[W-1:0] : {hi_q[W-2:0], lo_q[W-1]};
            lo_n = {lo_q[W-2:0], q_bit};
        end else begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_q[W-1:1]};
        end
        prod_fix = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        q_fix    = neg_q ? -lo_n : lo_n;
        r_fix    = neg_q ? -hi_n : hi_n;
        case (op_q)
            3'b000:                 res_n = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: res_n = prod_fix[2*W-1:W];
            3'b100, 3'b101:         res_n = q_fix;
            default:                res_n = r_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else if (Flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start_i) begin
                        op_q  <= MulDivCtrl_i;
                        neg_q <= neg_in;
                        hi_q  <= '0;
                        if (div_zero || div_ovf) begin
                            result_q <= spec_res;
                            state_q  <= StDone;
                        end else if (fast_hit) begin
                            result_q <= fast_res;
                            state_q  <= StDone;
                        end else begin
                            opnd_q  <= is_div ? b_abs : a_abs;
                            lo_q    <= is_div ? a_abs : b_abs;
                            cnt_q   <= CntW'(W);
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        result_q <= res_n;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (ResultReady_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Ready_o  = (state_q == StIdle);
    assign Valid_o  = (state_q == StDone);
    assign Result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (DATAWIDTH = 32).
// Multiply latency expectation follows MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif
    localparam int DivLat = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] SrcA_i = '0;
    logic [31:0] SrcB_i = '0;
    logic [2:0]  MulDivCtrl_i = '0;
    logic        Start_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic        ResultReady_i = 1'b0;
    logic        Ready_o;
    logic        Valid_o;
    logic [31:0] Result_o;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.DATAWIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .SrcA_i        (SrcA_i),
        .SrcB_i        (SrcB_i),
        .MulDivCtrl_i  (MulDivCtrl_i),
        .Start_i       (Start_i),
        .Flush_i       (Flush_i),
        .ResultReady_i (ResultReady_i),
        .Ready_o       (Ready_o),
        .Valid_o       (Valid_o),
        .Result_o      (Result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, measure edges to Valid_o (accepting edge counts as 1), optionally hold DONE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_exp,
                          input int hold);
        int          lat;
        bit          busy_ok;
        logic [31:0] prev;
        @(negedge clk);
        prev         = Result_o;
        MulDivCtrl_i = op;
        SrcA_i       = a;
        SrcB_i       = b;
        Start_i      = 1'b1;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (Valid_o !== 1'b1 && lat < 100) begin
            if (Ready_o !== 1'b0 || Result_o !== prev) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " valid"}, 32'(Valid_o), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " result"}, Result_o, exp);
        check({tag, " busy/stable"}, 32'({busy_ok, Ready_o}), 32'b10);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            MulDivCtrl_i = 3'b000;
            SrcA_i       = 32'd5;
            SrcB_i       = 32'd5;
            Start_i      = 1'b1;
            @(posedge clk);
            #1;
            check({tag, " hold result"}, Result_o, exp);
            check({tag, " hold valid/ready"}, 32'({Valid_o, Ready_o}), 32'b10);
        end
        @(negedge clk);
        Start_i       = 1'b0;
        ResultReady_i = 1'b1;
        @(posedge clk);
        #1;
        ResultReady_i = 1'b0;
        check({tag, " release"}, 32'({Valid_o, Ready_o}), 32'b01);
    endtask

    initial begin
        bit valid_seen;
        #12;
        check("reset ready", 32'(Ready_o), 32'd1);
        check("reset valid", 32'(Valid_o), 32'd0);
        check("reset result", Result_o, 32'd0);
        #5 rst_n = 1'b1;

        run_op("MUL 6x7", 3'b000, 32'd6, 32'd7, 32'd42, MulLat, 0);
        run_op("MULH -2x3", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, MulLat, 0);
        run_op("MULHU max^2", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat, 0);
        run_op("MULHSU -1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MulLat, 0);
        run_op("MUL -3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, MulLat, 0);
        run_op("MULH min^2", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat, 0);
        run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DivLat, 0);
        run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DivLat, 0);
        run_op("DIV 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DivLat, 0);
        run_op("REM 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, DivLat, 0);
        run_op("DIVU 100/3", 3'b101, 32'd100, 32'd3, 32'd33, DivLat, 0);
        run_op("REMU 100/3", 3'b111, 32'd100, 32'd3, 32'd1, DivLat, 0);
        run_op("DIVU 7/0", 3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("REMU 7/0", 3'b111, 32'd7, 32'd0, 32'd7, 1, 0);
        run_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("REM -5/0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);
        run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // Flush mid-CALC, with Start_i and ResultReady_i also high on the flush edge
        @(negedge clk);
        MulDivCtrl_i = 3'b101;
        SrcA_i       = 32'd100;
        SrcB_i       = 32'd3;
        Start_i      = 1'b1;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        Flush_i       = 1'b1;
        Start_i       = 1'b1;
        ResultReady_i = 1'b1;
        @(posedge clk);
        #1;
        Flush_i       = 1'b0;
        Start_i       = 1'b0;
        ResultReady_i = 1'b0;
        check("flush ready/valid", 32'({Valid_o, Ready_o}), 32'b01);
        valid_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (Valid_o !== 1'b0 || Ready_o !== 1'b1) valid_seen = 1'b1;
        end
        check("flush no valid", 32'(valid_seen), 32'd0);

        run_op("DIVU after flush", 3'b101, 32'd100, 32'd3, 32'd33, DivLat, 5);

        // Asynchronous reset in the middle of an iterative divide
        @(negedge clk);
        MulDivCtrl_i = 3'b101;
        SrcA_i       = 32'd100;
        SrcB_i       = 32'd3;
        Start_i      = 1'b1;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midcalc reset valid", 32'(Valid_o), 32'd0);
        check("midcalc reset ready", 32'(Ready_o), 32'd1);
        check("midcalc reset result", Result_o, 32'd0);
        #4 rst_n = 1'b1;

        run_op("MUL after reset", 3'b000, 32'd6, 32'd7, 32'd42, MulLat, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
